// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared width default and output-buffer occupancy type for the FIFO reader
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// rtl/fifo_reader_skid.sv - two-entry head/tail output buffer between FIFO read data and the stream
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output occ_t                  cnt
);

    occ_t                  cnt_next;
    logic                  pop;
    logic [DATA_WIDTH-1:0] tail;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt <= EMPTY;
        end else begin
            cnt <= cnt_next;
        end
    end

    always_comb begin
        cnt_next = cnt;
        case (cnt)
            EMPTY: begin
                if (capture) cnt_next = ONE;
            end
            ONE: begin
                if (capture && !pop)      cnt_next = TWO;
                else if (!capture && pop) cnt_next = EMPTY;
            end
            TWO: begin
                if (!capture && pop) cnt_next = ONE;
            end
            default: cnt_next = EMPTY;
        endcase
    end

    always_comb begin
        m_valid = (cnt != EMPTY);
        pop     = m_valid & m_ready;
    end

    // m_data is the head register itself, so it only moves on capture-to-head or a pop.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            m_data <= '0;
            tail   <= '0;
        end else begin
            case (cnt)
                EMPTY: begin
                    if (capture) m_data <= wr_data;
                end
                ONE: begin
                    if (capture) begin
                        if (pop) m_data <= wr_data;
                        else     tail   <= wr_data;
                    end
                end
                TWO: begin
                    if (pop) begin
                        m_data <= tail;
                        if (capture) tail <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - issues FIFO reads into a 2-entry output buffer; FIFO_READER_STATS_EN adds pop_cnt
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [15:0]           pop_cnt
`endif
);

    logic       rd_pend;
    logic       pop;
    logic [2:0] level;
    occ_t       cnt;

    assign pop = m_valid & m_ready;

    // Occupancy the buffer will hold once the in-flight word lands and this cycle's pop leaves.
    assign level = {1'b0, cnt} + {2'b00, rd_pend} - {2'b00, pop};

    // Gating with rst_ keeps the strobe low throughout reset even if the FIFO is non-empty.
    assign fifo_rd_en = rst_ & en & ~fifo_empty & (level < 3'd2);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= fifo_rd_en;
        end
    end

    fifo_reader_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_    (rst_),
        .capture (rd_pend),
        .wr_data (fifo_dout),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .cnt     (cnt)
    );

`ifdef FIFO_READER_STATS_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pop_cnt <= 16'd0;
        end else if (pop) begin
            pop_cnt <= pop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - directed vector bench for fifo_reader with a behavioural FIFO model
module tb_fifo_reader;

    logic       clk;
    logic       rst_;
    logic       en;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
`ifdef FIFO_READER_STATS_EN
    logic [15:0] pop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] fq[$];

    typedef struct {
        int         load_n;
        logic [7:0] load_base;
        logic       en;
        logic       rdy;
        logic       exp_rd;
        logic       exp_v;
        logic       chk_d;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[$];

    fifo_reader #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
`ifdef FIFO_READER_STATS_EN
        ,
        .pop_cnt    (pop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: registered empty flag, data valid the cycle after an accepted read, junk otherwise.
    initial begin
        fifo_empty = 1'b1;
        fifo_dout  = 8'h00;
    end
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) fifo_dout <= fq.pop_front();
        else                           fifo_dout <= 8'($urandom);
        fifo_empty <= (fq.size() == 0);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp_val);
        checks++;
        if (act !== exp_val) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp_val);
        end
    endtask

    task automatic add(input int ln, input logic [7:0] lb, input logic e, input logic r,
                       input logic xrd, input logic xv, input logic cd, input logic [7:0] xd);
        vec_t v;
        v.load_n = ln; v.load_base = lb; v.en = e; v.rdy = r;
        v.exp_rd = xrd; v.exp_v = xv; v.chk_d = cd; v.exp_d = xd;
        vecs.push_back(v);
    endtask

    task automatic wait_valid(input int max_cycles, output bit found);
        found = 1'b0;
        for (int c = 0; c < max_cycles && !found; c++) begin
            @(negedge clk); #1;
            if (m_valid) found = 1'b1;
        end
    endtask

    initial begin
        bit found;
        rst_ = 1'b0; en = 1'b0; m_ready = 1'b0;

        // single word 0xA5
        add(1, 8'hA5, 1, 1, 0, 0, 0, 8'h00);
        add(0, 8'h00, 1, 1, 1, 0, 0, 8'h00);
        add(0, 8'h00, 1, 1, 0, 0, 0, 8'h00);
        add(0, 8'h00, 1, 1, 0, 1, 1, 8'hA5);
        add(0, 8'h00, 1, 1, 0, 0, 0, 8'h00);
        // backpressure: four words, only two reads while stalled
        add(4, 8'h11, 1, 0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 1, 0, 1, 0, 0, 8'h00);
        add(0, 8'h00, 1, 0, 1, 0, 0, 8'h00);
        add(0, 8'h00, 1, 0, 0, 1, 1, 8'h11);
        add(0, 8'h00, 1, 0, 0, 1, 1, 8'h11);
        add(0, 8'h00, 1, 0, 0, 1, 1, 8'h11);
        add(0, 8'h00, 1, 1, 1, 1, 1, 8'h11);
        add(0, 8'h00, 1, 1, 1, 1, 1, 8'h12);
        add(0, 8'h00, 1, 1, 0, 1, 1, 8'h13);
        add(0, 8'h00, 1, 1, 0, 1, 1, 8'h14);
        add(0, 8'h00, 1, 1, 0, 0, 0, 8'h00);
        // pause: en dropped right after the first read
        add(3, 8'h21, 1, 1, 0, 0, 0, 8'h00);
        add(0, 8'h00, 1, 1, 1, 0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 0, 1, 1, 8'h21);
        add(0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        add(0, 8'h00, 1, 1, 1, 0, 0, 8'h00);
        add(0, 8'h00, 1, 1, 1, 0, 0, 8'h00);
        add(0, 8'h00, 1, 1, 0, 1, 1, 8'h22);
        add(0, 8'h00, 1, 1, 0, 1, 1, 8'h23);
        add(0, 8'h00, 1, 1, 0, 0, 0, 8'h00);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_rd_en", 0, {15'd0, fifo_rd_en}, 16'd0);
        chk("reset_valid", 0, {15'd0, m_valid}, 16'd0);
        chk("reset_data", 0, {8'd0, m_data}, 16'd0);
        @(negedge clk);
        rst_ = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            for (int k = 0; k < vecs[i].load_n; k++) fq.push_back(8'(vecs[i].load_base + k));
            en = vecs[i].en;
            m_ready = vecs[i].rdy;
            #1;
            chk("vec_rd_en", i, {15'd0, fifo_rd_en}, {15'd0, vecs[i].exp_rd});
            chk("vec_valid", i, {15'd0, m_valid}, {15'd0, vecs[i].exp_v});
            if (vecs[i].chk_d) chk("vec_data", i, {8'd0, m_data}, {8'd0, vecs[i].exp_d});
        end

        // streaming 0x01..0x10 with no gaps
        @(negedge clk);
        for (int k = 1; k <= 16; k++) fq.push_back(8'(k));
        en = 1'b1; m_ready = 1'b1;
        wait_valid(10, found);
        chk("stream_start", 0, {15'd0, found}, 16'd1);
        for (int k = 1; k <= 16; k++) begin
            chk("stream_valid", k, {15'd0, m_valid}, 16'd1);
            chk("stream_data", k, {8'd0, m_data}, 16'(k));
            @(negedge clk); #1;
        end
        chk("stream_end", 0, {15'd0, m_valid}, 16'd0);

        // reset with the buffer full, then a fresh word
        @(negedge clk);
        for (int k = 0; k < 4; k++) fq.push_back(8'(8'h31 + k));
        m_ready = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("full_valid", 0, {15'd0, m_valid}, 16'd1);
        chk("full_data", 0, {8'd0, m_data}, 16'h0031);
        rst_ = 1'b0;
        #1;
        chk("rst_async_valid", 0, {15'd0, m_valid}, 16'd0);
        chk("rst_async_data", 0, {8'd0, m_data}, 16'd0);
        chk("rst_async_rd_en", 0, {15'd0, fifo_rd_en}, 16'd0);
        fq.delete();
        fq.push_back(8'h5A);
        m_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("rst_hold_rd_en", k, {15'd0, fifo_rd_en}, 16'd0);
            chk("rst_hold_valid", k, {15'd0, m_valid}, 16'd0);
        end
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        chk("post_rst_rd_en", 0, {15'd0, fifo_rd_en}, 16'd1);
        wait_valid(5, found);
        chk("post_rst_found", 0, {15'd0, found}, 16'd1);
        chk("post_rst_data", 0, {8'd0, m_data}, 16'h005A);
        @(negedge clk); #1;
        chk("post_rst_drain", 0, {15'd0, m_valid}, 16'd0);

`ifdef FIFO_READER_STATS_EN
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        chk("stats_reset", 0, pop_cnt, 16'd0);
        @(negedge clk);
        rst_ = 1'b1;
        for (int k = 0; k < 32'h10002; k++) fq.push_back(8'(k));
        en = 1'b1; m_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 70000 && !found; c++) begin
            @(negedge clk); #1;
            if (fq.size() == 0 && !m_valid && !fifo_rd_en) found = 1'b1;
        end
        chk("stats_drain", 0, {15'd0, found}, 16'd1);
        chk("stats_wrap", 0, pop_cnt, 16'h0002);
        rst_ = 1'b0;
        #1;
        chk("stats_clear", 0, pop_cnt, 16'd0);
        @(negedge clk);
        rst_ = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
